rx_frame_ctrl: RTL

RX_FRAME_CTRL -- requirements
Module: rx_frame_ctrl

---
 rtl/rx_mac_pkg.sv | 22 ++
 rtl/rx_nib_cnt.sv | 26 ++
 rtl/rx_frame_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/rx_mac_pkg.sv
// rtl/rx_mac_pkg.sv - shared state encoding and frame field constants for the MII receive path.
package rx_mac_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_DA,
      ST_SA,
      ST_TYPE,
      ST_DATA,
      ST_DROP
   } rx_state_t;

   localparam logic [3:0] SFD_NIB     = 4'hD;
   localparam logic [3:0] PRE_NIB     = 4'h5;
   localparam int         DA_NIB      = 12;
   localparam int         SA_NIB      = 12;
   localparam int         TYPE_NIB    = 4;
   localparam int         MIN_FRM_NIB = 128;
   localparam int         MAX_FRM_NIB = 3036;

endpackage

// File: rtl/rx_nib_cnt.sv
// rtl/rx_nib_cnt.sv - saturating nibble counter with synchronous clear.
module rx_nib_cnt #(
   parameter int COUNT_WITCH = 12
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_clr,
   input  logic                   i_inc,
   output logic [COUNT_WITCH-1:0] o_cnt
);

   logic [COUNT_WITCH-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && !(&r_cnt)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/rx_frame_ctrl.sv
// rtl/rx_frame_ctrl.sv - MII receive framer: preamble/SFD detect, DA/SA/TYPE/DATA split, end-of-frame status.
// Optional frame length check is compiled in with RX_LEN_CHECK_EN.
module rx_frame_ctrl
   import rx_mac_pkg::*;
#(
   parameter int DATA_WITCH  = 4,
   parameter int COUNT_WITCH = 12,
   parameter int PRE_MIN_NIB = 6
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   I_rx_dv,
   input  logic                   I_rx_er,
   input  logic [DATA_WITCH-1:0]  I_rxd,
   output logic                   O_en_ck,
   output logic [DATA_WITCH-1:0]  O_da_hf,
   output logic                   O_data_vld,
   output logic [DATA_WITCH-1:0]  O_data,
   output logic                   O_frm_start,
   output logic                   O_frm_end,
   output logic                   O_frm_err,
   output logic [COUNT_WITCH-1:0] O_nib_cnt
);

   localparam logic [DATA_WITCH-1:0] L_SFD = DATA_WITCH'(SFD_NIB);
   localparam logic [DATA_WITCH-1:0] L_PRE = DATA_WITCH'(PRE_NIB);

   rx_state_t              r_state;
   logic [3:0]             r_pre_cnt;
   logic                   r_err_lat;
   logic                   r_sfd_seen;
   logic                   r_en_ck;
   logic [DATA_WITCH-1:0]  r_da_hf;
   logic                   r_data_vld;
   logic [DATA_WITCH-1:0]  r_data;
   logic                   r_frm_start;
   logic                   r_frm_end;
   logic                   r_frm_err;

   logic                   w_in_frame;
   logic                   w_accept;
   logic                   w_sfd_ok;
   logic                   w_fld_last;
   logic                   w_len_bad;
   logic [COUNT_WITCH-1:0] w_nib_cnt;
   logic [COUNT_WITCH-1:0] w_fld_cnt;

   always_comb begin
      w_in_frame = (r_state == ST_DA) || (r_state == ST_SA) ||
                   (r_state == ST_TYPE) || (r_state == ST_DATA);
      w_accept   = w_in_frame && I_rx_dv && !I_rx_er;
      w_sfd_ok   = (r_state == ST_PRE) && I_rx_dv && (I_rxd == L_SFD) &&
                   (r_pre_cnt >= 4'(PRE_MIN_NIB));
      w_fld_last = 1'b0;
      case (r_state)
         ST_DA:   w_fld_last = (w_fld_cnt == COUNT_WITCH'(DA_NIB - 1));
         ST_SA:   w_fld_last = (w_fld_cnt == COUNT_WITCH'(SA_NIB - 1));
         ST_TYPE: w_fld_last = (w_fld_cnt == COUNT_WITCH'(TYPE_NIB - 1));
         default: w_fld_last = 1'b0;
      endcase
   end

   rx_nib_cnt #(.COUNT_WITCH(COUNT_WITCH)) u_nib_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_sfd_ok),
      .i_inc (w_accept),
      .o_cnt (w_nib_cnt)
   );

   // Field position restarts at each field boundary; it is idle during DATA.
   rx_nib_cnt #(.COUNT_WITCH(COUNT_WITCH)) u_fld_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_sfd_ok || (w_accept && w_fld_last)),
      .i_inc (w_accept && (r_state != ST_DATA)),
      .o_cnt (w_fld_cnt)
   );

`ifdef RX_LEN_CHECK_EN
   assign w_len_bad = (w_nib_cnt < COUNT_WITCH'(MIN_FRM_NIB)) ||
                      (w_nib_cnt > COUNT_WITCH'(MAX_FRM_NIB)) ||
                      (&w_nib_cnt);
`else
   assign w_len_bad = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_pre_cnt   <= '0;
         r_err_lat   <= 1'b0;
         r_sfd_seen  <= 1'b0;
         r_en_ck     <= 1'b0;
         r_da_hf     <= '0;
         r_data_vld  <= 1'b0;
         r_data      <= '0;
         r_frm_start <= 1'b0;
         r_frm_end   <= 1'b0;
         r_frm_err   <= 1'b0;
      end else begin
         r_frm_start <= 1'b0;
         r_frm_end   <= 1'b0;
         r_en_ck     <= 1'b0;
         r_data_vld  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (I_rx_dv && (I_rxd == L_PRE)) begin
                  r_state   <= ST_PRE;
                  r_pre_cnt <= 4'd1;
               end
            end
            ST_PRE: begin
               if (!I_rx_dv) begin
                  r_state <= ST_IDLE;
               end else if (I_rxd == L_PRE) begin
                  if (r_pre_cnt != 4'hF) r_pre_cnt <= r_pre_cnt + 4'd1;
               end else if (w_sfd_ok) begin
                  r_state     <= ST_DA;
                  r_frm_start <= 1'b1;
                  r_frm_err   <= 1'b0;
                  r_err_lat   <= 1'b0;
                  r_sfd_seen  <= 1'b1;
               end else begin
                  r_state <= ST_DROP;
               end
            end
            ST_DA, ST_SA, ST_TYPE, ST_DATA: begin
               if (!I_rx_dv) begin
                  // An error sampled together with the dv fall still marks the frame bad.
                  r_state    <= ST_IDLE;
                  r_frm_end  <= 1'b1;
                  r_frm_err  <= r_err_lat || I_rx_er || (r_state != ST_DATA) || w_len_bad;
                  r_sfd_seen <= 1'b0;
               end else if (I_rx_er) begin
                  r_state   <= ST_DROP;
                  r_err_lat <= 1'b1;
               end else begin
                  if (r_state == ST_DA) begin
                     r_en_ck <= 1'b1;
                     r_da_hf <= I_rxd;
                  end else begin
                     r_data_vld <= 1'b1;
                     r_data     <= I_rxd;
                  end
                  if (w_fld_last) begin
                     case (r_state)
                        ST_DA:   r_state <= ST_SA;
                        ST_SA:   r_state <= ST_TYPE;
                        default: r_state <= ST_DATA;
                     endcase
                  end
               end
            end
            ST_DROP: begin
               if (!I_rx_dv) begin
                  r_state    <= ST_IDLE;
                  r_sfd_seen <= 1'b0;
                  if (r_sfd_seen) begin
                     r_frm_end <= 1'b1;
                     r_frm_err <= 1'b1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign O_en_ck     = r_en_ck;
   assign O_da_hf     = r_da_hf;
   assign O_data_vld  = r_data_vld;
   assign O_data      = r_data;
   assign O_frm_start = r_frm_start;
   assign O_frm_end   = r_frm_end;
   assign O_frm_err   = r_frm_err;
   assign O_nib_cnt   = w_nib_cnt;

endmodule
